// File: rtl/uart_tb_pkg.sv
// rtl/uart_tb_pkg.sv - shared state encoding, data width and parity helper for the UART capture receiver
package uart_tb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_capture_if.sv
// rtl/uart_rx_capture_if.sv - serial input and character/strobe outputs of the UART capture receiver
interface uart_rx_capture_if;
  logic       rx;
  logic       data_valid;
  logic [7:0] data;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport slave  (input rx,  output data_valid, data, frame_err, parity_err, busy);
  modport master (output rx, input  data_valid, data, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous rx line, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;
endmodule

// File: rtl/uart_rx_capture.sv
// rtl/uart_rx_capture.sv - oversampling UART receiver top; define UART_RX_PARITY_EN for an even parity bit
module uart_rx_capture
  import uart_tb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_capture_if.slave   bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (bus.rx),
    .rx_s_o (rx_s)
  );

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     data_q, data_d;
  logic           dv_q, dv_d;
  logic           fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic           pe_q, pe_d;
  logic           par_bad_q, par_bad_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q      <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      pe_q      <= pe_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // bit_q doubles as the stop-bit index once the data bits are in
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d      = 1'b0;
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = (rx_s != even_parity(shreg_q));
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end else if (bit_q == LAST_STOP) begin
            dv_d    = 1'b1;
            data_d  = shreg_q;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            pe_d = par_bad_q;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_valid = dv_q;
  assign bus.data       = data_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule
